// File: rtl/uart_cmd_decoder.sv
// Frame parser between uart_rx and the SPI master: 'W' A D writes, 'R' A reads, 'X' pulses a
// system reset. Each W/R frame (or error) returns exactly one byte toward the UART Tx FIFO.
module uart_cmd_decoder #(
    parameter int unsigned BYTE_TIMEOUT = 1000000,
    parameter int unsigned SPI_TIMEOUT  = 4096,
    parameter int unsigned RESET_CYCLES = 10,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_spi_start,
    output logic [7:0] o_spi_upper,
    output logic [7:0] o_spi_lower,
    input  logic       i_spi_busy,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rx_byte,
    output logic       o_resp_valid,
    output logic [7:0] o_resp_byte,
    input  logic       i_resp_ready,
    output logic       o_reset_all,
    output logic       o_cmd_error,
    output logic       o_idle
);
    localparam logic [7:0]  OP_WRITE   = 8'h57;
    localparam logic [7:0]  OP_READ    = 8'h52;
    localparam logic [7:0]  OP_RESET   = 8'h58;
    localparam logic [19:0] BYTE_LIMIT = 20'(BYTE_TIMEOUT - 1);
    localparam logic [19:0] SPI_LIMIT  = 20'(SPI_TIMEOUT - 1);
    localparam logic [3:0]  RST_LIMIT  = 4'(RESET_CYCLES - 1);

    generate
        if (RESET_CYCLES < 1 || RESET_CYCLES > 15) begin : g_bad_reset_cycles
            $error("RESET_CYCLES must be within 1..15");
        end
        if (BYTE_TIMEOUT < 1 || BYTE_TIMEOUT > 1048575 ||
            SPI_TIMEOUT < 1 || SPI_TIMEOUT > 1048575) begin : g_bad_timeouts
            $error("timeouts must fit the 20-bit counter");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, SPI_REQ, SPI_WAIT, RESP, RST_PULSE
    } state_t;

    state_t      state_reg, state_next;
    logic        is_read_reg, is_read_next;
    logic [7:0]  stage_upper_reg, stage_upper_next;
    logic [7:0]  stage_lower_reg, stage_lower_next;
    logic [7:0]  spi_upper_reg, spi_upper_next;
    logic [7:0]  spi_lower_reg, spi_lower_next;
    logic        loaded_reg, loaded_next;
    logic [19:0] timer_reg, timer_next;
    logic [3:0]  rst_cnt_reg, rst_cnt_next;
    logic [7:0]  resp_reg, resp_next;
    logic        error_reg, error_next;
    logic        spi_start;
    logic [19:0] timer_inc;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg       <= IDLE;
            is_read_reg     <= 1'b0;
            stage_upper_reg <= 8'h00;
            stage_lower_reg <= 8'h00;
            spi_upper_reg   <= 8'h00;
            spi_lower_reg   <= 8'h00;
            loaded_reg      <= 1'b0;
            timer_reg       <= 20'd0;
            rst_cnt_reg     <= 4'd0;
            resp_reg        <= 8'h00;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            is_read_reg     <= is_read_next;
            stage_upper_reg <= stage_upper_next;
            stage_lower_reg <= stage_lower_next;
            spi_upper_reg   <= spi_upper_next;
            spi_lower_reg   <= spi_lower_next;
            loaded_reg      <= loaded_next;
            timer_reg       <= timer_next;
            rst_cnt_reg     <= rst_cnt_next;
            resp_reg        <= resp_next;
            error_reg       <= error_next;
        end
    end

    assign timer_inc = (timer_reg == 20'hFFFFF) ? timer_reg : timer_reg + 20'd1;

    always_comb begin
        state_next       = state_reg;
        is_read_next     = is_read_reg;
        stage_upper_next = stage_upper_reg;
        stage_lower_next = stage_lower_reg;
        spi_upper_next   = spi_upper_reg;
        spi_lower_next   = spi_lower_reg;
        loaded_next      = loaded_reg;
        rst_cnt_next     = 4'd0;
        resp_next        = resp_reg;
        error_next       = 1'b0;
        spi_start        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == OP_WRITE || i_rx_byte == OP_READ) begin
                        is_read_next = (i_rx_byte == OP_READ);
                        state_next   = GET_ADDR;
                    end else if (i_rx_byte == OP_RESET) begin
                        state_next = RST_PULSE;
                    end else begin
                        resp_next  = NAK_BYTE;
                        error_next = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (i_rx_dv) begin
                    if (state_reg == GET_DATA) begin
                        stage_lower_next = i_rx_byte;
                        state_next       = SPI_REQ;
                    end else if (is_read_reg) begin
                        stage_upper_next = {1'b1, i_rx_byte[6:0]};
                        stage_lower_next = 8'h00;
                        state_next       = SPI_REQ;
                    end else begin
                        stage_upper_next = {1'b0, i_rx_byte[6:0]};
                        state_next       = GET_DATA;
                    end
                end else if (timer_reg == BYTE_LIMIT) begin
                    resp_next  = NAK_BYTE;
                    error_next = 1'b1;
                    state_next = RESP;
                end
            end
            SPI_REQ: begin
                // Outputs are loaded only while the SPI is idle, then start follows.
                if (!i_spi_busy) begin
                    if (loaded_reg) begin
                        spi_start   = 1'b1;
                        loaded_next = 1'b0;
                        state_next  = SPI_WAIT;
                    end else begin
                        spi_upper_next = stage_upper_reg;
                        spi_lower_next = stage_lower_reg;
                        loaded_next    = 1'b1;
                    end
                end
            end
            SPI_WAIT: begin
                if (i_spi_done) begin
                    resp_next  = is_read_reg ? i_spi_rx_byte : ACK_BYTE;
                    state_next = RESP;
                end else if (timer_reg == SPI_LIMIT) begin
                    resp_next  = NAK_BYTE;
                    error_next = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) state_next = IDLE;
            end
            RST_PULSE: begin
                rst_cnt_next = rst_cnt_reg + 4'd1;
                if (rst_cnt_reg == RST_LIMIT) begin
                    rst_cnt_next = 4'd0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (i_rx_dv && (state_reg == SPI_REQ || state_reg == SPI_WAIT ||
                        state_reg == RESP || state_reg == RST_PULSE)) begin
            error_next = 1'b1;
        end

        // Every state change restarts the shared byte/SPI timeout counter.
        timer_next = (state_next != state_reg) ? 20'd0 : timer_inc;
    end

    assign o_spi_start  = spi_start;
    assign o_spi_upper  = spi_upper_reg;
    assign o_spi_lower  = spi_lower_reg;
    assign o_resp_valid = (state_reg == RESP);
    assign o_resp_byte  = resp_reg;
    assign o_reset_all  = (state_reg == RST_PULSE);
    assign o_cmd_error  = error_reg;
    assign o_idle       = (state_reg == IDLE);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: SPI transactions and response bytes are checked against
// scoreboard queues filled when each frame is sent; timing and error behaviour checked inline.
module tb_uart_cmd_decoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       spi_start;
    logic [7:0] spi_upper;
    logic [7:0] spi_lower;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_rx_byte;
    logic       resp_valid;
    logic [7:0] resp_byte;
    logic       resp_ready;
    logic       reset_all;
    logic       cmd_error;
    logic       idle;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] spi_q[$];
    logic [7:0]  resp_q[$];

    uart_cmd_decoder #(
        .BYTE_TIMEOUT(100),
        .SPI_TIMEOUT (64),
        .RESET_CYCLES(10),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_rx_dv      (rx_dv),
        .i_rx_byte    (rx_byte),
        .o_spi_start  (spi_start),
        .o_spi_upper  (spi_upper),
        .o_spi_lower  (spi_lower),
        .i_spi_busy   (spi_busy),
        .i_spi_done   (spi_done),
        .i_spi_rx_byte(spi_rx_byte),
        .o_resp_valid (resp_valid),
        .o_resp_byte  (resp_byte),
        .i_resp_ready (resp_ready),
        .o_reset_all  (reset_all),
        .o_cmd_error  (cmd_error),
        .o_idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expectations when the DUT issues a transaction.
    always @(negedge clk) begin
        logic [15:0] e_spi;
        logic [7:0]  e_resp;
        if (spi_start === 1'b1) begin
            if (spi_q.size() == 0) chk("spi_start_unexpected", spi_start, 0);
            else begin
                e_spi = spi_q.pop_front();
                $display("spi txn upper=%02h lower=%02h", spi_upper, spi_lower);
                chk("spi_upper", spi_upper, e_spi[15:8]);
                chk("spi_lower", spi_lower, e_spi[7:0]);
            end
        end
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (resp_q.size() == 0) chk("resp_unexpected", resp_valid, 0);
            else begin
                e_resp = resp_q.pop_front();
                $display("resp txn byte=%02h", resp_byte);
                chk("resp_byte", resp_byte, e_resp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        cyc();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (spi_start !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (resp_valid !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    task automatic spi_finish(input logic [7:0] rdata);
        cyc();
        spi_done    = 1'b1;
        spi_rx_byte = rdata;
        cyc();
        spi_done    = 1'b0;
        spi_rx_byte = 8'h00;
    endtask

    initial begin
        int n;
        int bad;
        int cnt;
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; spi_busy = 1'b0;
        spi_done = 1'b0; spi_rx_byte = 8'h00; resp_ready = 1'b1;
        cyc(); cyc();
        chk("rst_idle", idle, 1);
        chk("rst_outputs", {spi_start, resp_valid, reset_all, cmd_error}, 4'b0000);
        chk("rst_spi_bytes", {spi_upper, spi_lower, resp_byte}, 24'h0);
        rst_n = 1'b1;
        cyc();

        // 1: write frame, response held until ready
        resp_ready = 1'b0;
        send(8'h57); send(8'h09); send(8'h32);
        spi_q.push_back(16'h0932); resp_q.push_back(8'h06);
        wait_start(n);
        chk("t1_start", spi_start, 1);
        cyc();
        chk("t1_start_single", spi_start, 0);
        spi_done = 1'b1; spi_rx_byte = 8'h5A; cyc(); spi_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1 || resp_byte !== 8'h06) bad++;
            cyc();
        end
        chk("t1_hold", bad, 0);
        resp_ready = 1'b1;
        cyc();
        chk("t1_valid_drop", resp_valid, 0);
        chk("t1_idle", idle, 1);

        // done outside SPI_WAIT is ignored
        spi_done = 1'b1; spi_rx_byte = 8'hFF; cyc(); spi_done = 1'b0;
        chk("done_ignored", {idle, resp_valid}, 2'b10);

        // 2: read frame, 50 cycles of backpressure
        resp_ready = 1'b0;
        send(8'h52); send(8'h78);
        spi_q.push_back(16'hF800); resp_q.push_back(8'hA5);
        wait_start(n);
        chk("t2_start", spi_start, 1);
        spi_finish(8'hA5);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (resp_valid !== 1'b1 || resp_byte !== 8'hA5) bad++;
            cyc();
        end
        chk("t2_hold50", bad, 0);
        resp_ready = 1'b1;
        cyc();
        chk("t2_valid_drop", resp_valid, 0);

        // 3: reset pulse
        send(8'h58);
        cnt = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (reset_all === 1'b1) cnt++;
            if (resp_valid !== 1'b0) bad++;
            cyc();
        end
        chk("t3_reset_len", cnt, 10);
        chk("t3_no_resp", bad, 0);
        chk("t3_idle", idle, 1);

        // 4a: bad opcode
        resp_q.push_back(8'h15);
        send(8'h41);
        chk("t4_badop_err", {resp_valid, cmd_error}, 2'b11);
        cyc();
        chk("t4_badop_err_pulse", cmd_error, 0);

        // 4b: byte timeout after opcode
        resp_q.push_back(8'h15);
        send(8'h57);
        wait_valid(n);
        chk("t4_byte_timeout_cycles", n, 100);
        chk("t4_byte_timeout_err", cmd_error, 1);
        cyc();

        // 4c: byte arriving exactly at expiry wins
        send(8'h57);
        for (int i = 0; i < 99; i++) cyc();
        send(8'h05);
        chk("t4_edge_accept", {resp_valid, cmd_error, idle}, 3'b000);
        send(8'h11);
        spi_q.push_back(16'h0511); resp_q.push_back(8'h06);
        wait_start(n);
        chk("t4_edge_start", spi_start, 1);
        spi_finish(8'h00);
        wait_valid(n);
        chk("t4_edge_resp", resp_valid, 1);
        cyc();

        // 4d: SPI timeout
        send(8'h52); send(8'h10);
        spi_q.push_back(16'h9000); resp_q.push_back(8'h15);
        wait_start(n);
        chk("t4_spi_start", spi_start, 1);
        cyc();
        wait_valid(n);
        chk("t4_spi_timeout_cycles", n, 64);
        chk("t4_spi_timeout_err", cmd_error, 1);
        cyc();

        // 5a: start held off while busy, outputs untouched meanwhile
        send(8'h57); send(8'h03);
        spi_busy = 1'b1;
        send(8'h44);
        spi_q.push_back(16'h0344); resp_q.push_back(8'h06);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (spi_start !== 1'b0 || spi_upper !== 8'h90 || spi_lower !== 8'h00) bad++;
            cyc();
        end
        chk("t5_busy_hold", bad, 0);
        spi_busy = 1'b0;
        wait_start(n);
        chk("t5_start_after_busy", spi_start, 1);
        chk("t5_start_delay", (n <= 3), 1);
        spi_finish(8'h00);
        wait_valid(n);
        cyc();

        // 5b: overrun byte during SPI_WAIT
        send(8'h52); send(8'h22);
        spi_q.push_back(16'hA200); resp_q.push_back(8'h3C);
        wait_start(n);
        cyc();
        send(8'h99);
        chk("t5_overrun_err", {cmd_error, idle}, 2'b10);
        spi_done = 1'b1; spi_rx_byte = 8'h3C; cyc(); spi_done = 1'b0;
        wait_valid(n);
        chk("t5_overrun_resp", resp_valid, 1);
        cyc();

        // 6: async reset during SPI_WAIT
        send(8'h52); send(8'h33);
        spi_q.push_back(16'hB300);
        wait_start(n);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wait_rst_outs", {idle, spi_start, resp_valid, reset_all, cmd_error}, 5'b10000);
        chk("t6_wait_rst_spi", {spi_upper, spi_lower}, 16'h0000);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 6: async reset during RESP
        resp_ready = 1'b0;
        send(8'h57); send(8'h01); send(8'h02);
        spi_q.push_back(16'h0102);
        wait_start(n);
        spi_finish(8'h00);
        chk("t6_resp_pending", resp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_resp_rst", {idle, resp_valid, resp_byte}, 10'h200);
        cyc();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        cyc();

        send(8'h52); send(8'h00);
        spi_q.push_back(16'h8000); resp_q.push_back(8'h7E);
        wait_start(n);
        chk("t6_after_start", spi_start, 1);
        spi_finish(8'h7E);
        wait_valid(n);
        chk("t6_after_resp", resp_valid, 1);
        cyc(); cyc();
        chk("t6_after_idle", idle, 1);

        chk("spi_q_drained", spi_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Downstream of uart_rx and upstream of spi and the SPI-Rx/UART-Tx FIFO. Parses framed binary commands from the PC byte stream and turns them into single Bluejay SPI transactions or a system reset pulse. Returns one status or data byte per command to the UART Tx path. Replaces the hard-coded per-character command decode with a general register read/write protocol that includes timeouts.

Parameters:
BYTE_TIMEOUT, 1000000, max sys clocks between bytes of one frame (20 ms at 50 MHz) before the frame is aborted
SPI_TIMEOUT, 4096, max clocks from o_spi_start to i_spi_done before NAK
RESET_CYCLES, 10, length of the o_reset_all pulse in clocks (200 ns at 50 MHz)
ACK_BYTE, 8'h06, response to a successful write
NAK_BYTE, 8'h15, response to a bad opcode, byte timeout or SPI timeout

Ports:
i_clock  in  1  system clock (sys_clk)
i_reset_n  in  1  asynchronous active-low reset; clears all state
i_rx_dv  in  1  uart_rx o_Rx_DV; 1-cycle byte strobe
i_rx_byte  in  8  uart_rx o_Rx_Byte; valid when i_rx_dv=1
o_spi_start  out  1  1-cycle start pulse to spi start_transfer
o_spi_upper  out  8  spi Tx_Upper_Byte (address/R-W byte)
o_spi_lower  out  8  spi Tx_Lower_Byte (data)
i_spi_busy  in  1  spi busy
i_spi_done  in  1  spi o_transaction_complete; 1-cycle strobe
i_spi_rx_byte  in  8  spi Rx_Lower_Byte; valid when i_spi_done=1
o_resp_valid  out  1  response byte valid
o_resp_byte  out  8  response byte
i_resp_ready  in  1  downstream FIFO not full
o_reset_all  out  1  active-high system reset pulse request
o_cmd_error  out  1  1-cycle pulse on NAK or dropped byte
o_idle  out  1  high in IDLE

Behaviour:
- Reset: every output is 0 except o_idle=1. State = IDLE. All counters = 0.
- Frames:
  - 'W'(8'h57) A D: SPI write, upper={1'b0,A[6:0]}, lower=D. Response ACK_BYTE.
  - 'R'(8'h52) A: SPI read, upper={1'b1,A[6:0]}, lower=8'h00. Response is i_spi_rx_byte.
  - 'X'(8'h58): o_reset_all high for exactly RESET_CYCLES cycles. No response.
  - Any other opcode in IDLE: NAK_BYTE response plus an o_cmd_error pulse.
- States: IDLE, GET_ADDR, GET_DATA, SPI_REQ, SPI_WAIT, RESP, RST_PULSE.
  - IDLE -> GET_ADDR on W/R. IDLE -> RST_PULSE on X. IDLE -> RESP(NAK) on a bad opcode.
  - GET_ADDR -> GET_DATA for W. GET_ADDR -> SPI_REQ for R.
  - GET_DATA -> SPI_REQ.
  - SPI_REQ: o_spi_upper/o_spi_lower are registered. The state waits while i_spi_busy=1. With busy=0, o_spi_start=1 for one cycle and the state moves to SPI_WAIT. Start occurs no earlier than 1 cycle after the final frame byte's i_rx_dv.
  - SPI_WAIT -> RESP on i_spi_done. The response is latched in that cycle and o_resp_valid rises the next cycle. If SPI_TIMEOUT cycles elapse without i_spi_done -> RESP(NAK), with an o_cmd_error pulse.
  - RESP: o_resp_valid and o_resp_byte are held stable until i_resp_ready=1. The transfer occurs in a cycle with valid&ready. o_resp_valid=0 and the state returns to IDLE the next cycle.
  - RST_PULSE -> IDLE after RESET_CYCLES.
- o_spi_upper/o_spi_lower hold their values from SPI_REQ until the next command loads new ones. They are never changed while the SPI is busy.
- Byte timeout:
  - A counter runs in GET_ADDR and GET_DATA and is cleared on every i_rx_dv.
  - Reaching BYTE_TIMEOUT -> RESP(NAK) plus an o_cmd_error pulse, and the partial frame is discarded.
  - If i_rx_dv occurs in the same cycle as expiry, the byte wins: it is accepted and the counter is cleared.
- Overrun: i_rx_dv in SPI_REQ, SPI_WAIT, RESP or RST_PULSE drops the byte and pulses o_cmd_error. State is unchanged.
- i_spi_done outside SPI_WAIT is ignored.
- Asynchronous reset mid-operation forces IDLE immediately. o_spi_start, o_resp_valid and o_reset_all drop without completing. Any SPI transaction in flight is abandoned; the spi block is reset by the system reset.
- Timeout counters are 20 bits wide and saturate. The RESET_CYCLES counter is 4 bits wide; RESET_CYCLES ≤ 15 is enforced by a generate-time check.

Test Plan:
1. Write: bytes 57,09,32 with i_spi_busy=0 -> one o_spi_start, upper=8'h09, lower=8'h32. Drive i_spi_done -> o_resp_byte=8'h06, held until i_resp_ready.
2. Read: bytes 52,78; i_spi_done with i_spi_rx_byte=8'hA5 -> upper=8'hF8, lower=8'h00, response 8'hA5. With i_resp_ready=0 for 50 cycles, valid and byte stay stable.
3. Reset: byte 58 -> o_reset_all high exactly 10 cycles, no o_resp_valid, o_idle=1 afterwards.
4. Errors, with BYTE_TIMEOUT=100, SPI_TIMEOUT=64:
   - Byte 41 -> NAK 8'h15 plus an o_cmd_error pulse.
   - Byte 57 then silence -> NAK at cycle 100.
   - A second byte arriving exactly at expiry is accepted.
   - No i_spi_done -> NAK 64 cycles after o_spi_start.
5. Busy/overrun:
   - Hold i_spi_busy=1 for 30 cycles in SPI_REQ -> o_spi_start delayed until busy falls.
   - A byte arriving during SPI_WAIT -> o_cmd_error, and the frame result is unaffected.
6. Pull i_reset_n low during SPI_WAIT and during RESP -> all outputs return to reset values asynchronously. A subsequent 52,00 frame completes normally.
